// File: rtl/vga_pkg.sv
// Shared video constants and the packed timing/colour bus carried through
// the pixel pipeline.
package vga_pkg;

  localparam int unsigned H_ACTIVE  = 800;
  localparam int unsigned V_ACTIVE  = 600;
  localparam int unsigned CNT_W     = 11;
  localparam int unsigned RGB_W     = 12;
  localparam int unsigned POS_W     = 12;
  localparam int unsigned ADDR_W    = 12;
  localparam int unsigned IMG_W_DEF = 64;
  localparam int unsigned IMG_H_DEF = 64;
  localparam logic [RGB_W-1:0] KEY_COLOR_DEF = 12'hF0F;

  typedef struct packed {
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;
    logic [RGB_W-1:0] rgb;
  } vga_bus_t;

endpackage

// File: rtl/draw_image_rom_if.sv
// Signal bundle of draw_image_rom: video stream in/out, image position and
// the external image ROM address/data pair.
interface draw_image_rom_if;
  import vga_pkg::*;

  logic [CNT_W-1:0]  hcount_in;
  logic [CNT_W-1:0]  vcount_in;
  logic              hsync_in;
  logic              vsync_in;
  logic              hblnk_in;
  logic              vblnk_in;
  logic [RGB_W-1:0]  rgb_in;
  logic [POS_W-1:0]  xpos;
  logic [POS_W-1:0]  ypos;
  logic [RGB_W-1:0]  rgb_pixel;
  logic [ADDR_W-1:0] pixel_addr;
  logic [CNT_W-1:0]  hcount_out;
  logic [CNT_W-1:0]  vcount_out;
  logic              hsync_out;
  logic              vsync_out;
  logic              hblnk_out;
  logic              vblnk_out;
  logic [RGB_W-1:0]  rgb_out;

  // Upstream pipeline, position controller and ROM side.
  modport master (
    output hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in,
    output rgb_in, xpos, ypos, rgb_pixel,
    input  pixel_addr, hcount_out, vcount_out, hsync_out, vsync_out,
    input  hblnk_out, vblnk_out, rgb_out
  );

  // The image overlay stage itself.
  modport slave (
    input  hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in,
    input  rgb_in, xpos, ypos, rgb_pixel,
    output pixel_addr, hcount_out, vcount_out, hsync_out, vsync_out,
    output hblnk_out, vblnk_out, rgb_out
  );

endinterface

// File: rtl/signal_delay.sv
// Fixed-length shift-register delay, all stages cleared by async reset.
module signal_delay #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] sr [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else begin
      sr[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/draw_image_rom.sv
// Overlays an IMG_W x IMG_H bitmap from an external synchronous ROM onto the
// video stream at the frame-latched (xpos, ypos); 3-clock pipeline.
module draw_image_rom
  import vga_pkg::*;
#(
  parameter int unsigned      IMG_W     = IMG_W_DEF,
  parameter int unsigned      IMG_H     = IMG_H_DEF,
  parameter logic [RGB_W-1:0] KEY_COLOR = KEY_COLOR_DEF
) (
  input logic             clk,
  input logic             rst,
  draw_image_rom_if.slave bus
);

  localparam int unsigned XB    = $clog2(IMG_W);
  localparam int unsigned YB    = $clog2(IMG_H);
  localparam int unsigned BUS_W = $bits(vga_bus_t);

  logic [POS_W-1:0]  x_l, y_l, x_eff, y_eff, dx, dy;
  logic              frame_start, in_rect, in_rect_s1, in_rect_d;
  logic [12:0]       h13, v13, x13, y13;
  logic [ADDR_W-1:0] addr_s1;
  logic [RGB_W-1:0]  pixel_q;
  vga_bus_t          bus_in, bus_d;

  assign frame_start = (bus.hcount_in == '0) && (bus.vcount_in == '0);

  // The frame-start pixel already uses the newly latched position, so a
  // position change lands on the whole frame.
  assign x_eff = frame_start ? bus.xpos : x_l;
  assign y_eff = frame_start ? bus.ypos : y_l;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_l <= '0;
      y_l <= '0;
    end else if (frame_start) begin
      x_l <= bus.xpos;
      y_l <= bus.ypos;
    end
  end

  // 13-bit compares keep x+IMG_W from wrapping near the top of the range.
  assign h13 = {2'b00, bus.hcount_in};
  assign v13 = {2'b00, bus.vcount_in};
  assign x13 = {1'b0, x_eff};
  assign y13 = {1'b0, y_eff};

  assign in_rect = (h13 >= x13) && (h13 < x13 + 13'(IMG_W)) &&
                   (v13 >= y13) && (v13 < y13 + 13'(IMG_H));

  assign dx = {1'b0, bus.hcount_in} - x_eff;
  assign dy = {1'b0, bus.vcount_in} - y_eff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_s1    <= '0;
      in_rect_s1 <= 1'b0;
    end else begin
      addr_s1    <= in_rect ? ADDR_W'({dy[YB-1:0], dx[XB-1:0]}) : '0;
      in_rect_s1 <= in_rect;
    end
  end

  assign bus.pixel_addr = addr_s1;

  // ROM data is registered once more so every operand of the final merge sits
  // three registers from the inputs; the merge itself is then combinational.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pixel_q <= '0;
    else     pixel_q <= bus.rgb_pixel;
  end

  signal_delay #(.WIDTH(1), .DEPTH(2)) u_rect_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (in_rect_s1),
    .dout (in_rect_d)
  );

  assign bus_in = '{hcount: bus.hcount_in, vcount: bus.vcount_in,
                    hsync:  bus.hsync_in,  vsync:  bus.vsync_in,
                    hblnk:  bus.hblnk_in,  vblnk:  bus.vblnk_in,
                    rgb:    bus.rgb_in};

  signal_delay #(.WIDTH(BUS_W), .DEPTH(3)) u_bus_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (bus_in),
    .dout (bus_d)
  );

  assign bus.hcount_out = bus_d.hcount;
  assign bus.vcount_out = bus_d.vcount;
  assign bus.hsync_out  = bus_d.hsync;
  assign bus.vsync_out  = bus_d.vsync;
  assign bus.hblnk_out  = bus_d.hblnk;
  assign bus.vblnk_out  = bus_d.vblnk;

  always_comb begin
    bus.rgb_out = bus_d.rgb;
    if (bus_d.hblnk || bus_d.vblnk)
      bus.rgb_out = '0;
    else if (in_rect_d && (pixel_q != KEY_COLOR))
      bus.rgb_out = pixel_q;
  end

endmodule

// File: tb/tb_draw_image_rom.sv
// Scoreboard bench for draw_image_rom: a reference model predicts each
// driven pixel's output and ROM address; both are compared on arrival.
module tb_draw_image_rom;
  import vga_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  draw_image_rom_if bus ();

  draw_image_rom #(.IMG_W(64), .IMG_H(64), .KEY_COLOR(12'hF0F)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          cyc;
    int          h;
    int          v;
    logic [37:0] exp;
    int          pmode;
    logic [11:0] pv;
  } exp_t;

  typedef struct {
    int          cyc;
    logic [11:0] a;
  } aexp_t;

  exp_t  q[$];
  aexp_t aq[$];
  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;
  int    x_m   = 0;
  int    y_m   = 0;
  logic  hs    = 1'b0;

  function automatic logic [11:0] rom_f(input logic [11:0] a);
    return (a == 12'd65) ? 12'hF0F : a;
  endfunction

  // External synchronous ROM: data one clock after the address.
  always @(posedge clk) bus.rgb_pixel <= rom_f(bus.pixel_addr);

  function automatic logic [37:0] out_vec();
    return {bus.hcount_out, bus.vcount_out, bus.hsync_out, bus.vsync_out,
            bus.hblnk_out, bus.vblnk_out, bus.rgb_out};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic collect();
    exp_t  e;
    aexp_t ea;
    if (q.size() > 0 && q[0].cyc + 3 == cyc) begin
      e = q.pop_front();
      check($sformatf("pix(%0d,%0d)", e.h, e.v), 64'(out_vec()), 64'(e.exp));
      if (e.pmode != 0)
        check($sformatf("probe_rgb(%0d,%0d)", e.h, e.v), 64'(bus.rgb_out), 64'(e.pv));
    end
    if (aq.size() > 0 && aq[0].cyc + 1 == cyc) begin
      ea = aq.pop_front();
      check("pixel_addr", 64'(bus.pixel_addr), 64'(ea.a));
    end
  endtask

  // pmode: 0 none, 1 expect constant pv, 2 expect the driven rgb_in.
  task automatic px(input int h, input int v, input logic [11:0] rgb,
                    input int pmode = 0, input logic [11:0] pv = '0);
    exp_t        e;
    aexp_t       ea;
    logic        hb, vb, vs, inr;
    logic [11:0] a, d, r;
    @(negedge clk);
    cyc++;
    collect();
    hs = ~hs;
    hb = (h >= 800);
    vb = (v >= 600);
    vs = (v >= 601) && (v < 605);
    if (h == 0 && v == 0) begin
      x_m = int'(bus.xpos);
      y_m = int'(bus.ypos);
    end
    inr = (h >= x_m) && (h < x_m + 64) && (v >= y_m) && (v < y_m + 64);
    a   = inr ? 12'((v - y_m) * 64 + (h - x_m)) : 12'd0;
    d   = rom_f(a);
    if (hb || vb)               r = 12'd0;
    else if (inr && d != 12'hF0F) r = d;
    else                        r = rgb;
    bus.hcount_in = 11'(h);
    bus.vcount_in = 11'(v);
    bus.hsync_in  = hs;
    bus.vsync_in  = vs;
    bus.hblnk_in  = hb;
    bus.vblnk_in  = vb;
    bus.rgb_in    = rgb;
    e.cyc   = cyc;
    e.h     = h;
    e.v     = v;
    e.exp   = {11'(h), 11'(v), hs, vs, hb, vb, r};
    e.pmode = pmode;
    e.pv    = (pmode == 2) ? rgb : pv;
    q.push_back(e);
    ea.cyc = cyc;
    ea.a   = a;
    aq.push_back(ea);
  endtask

  task automatic line(input int v, input int h0, input int h1);
    for (int h = h0; h <= h1; h++) px(h, v, 12'($urandom));
  endtask

  task automatic flush();
    repeat (4) begin
      @(negedge clk);
      cyc++;
      collect();
    end
  endtask

  initial begin
    bus.hcount_in = 11'd5;
    bus.vcount_in = '0;
    bus.hsync_in  = 1'b0;
    bus.vsync_in  = 1'b0;
    bus.hblnk_in  = 1'b0;
    bus.vblnk_in  = 1'b0;
    bus.rgb_in    = 12'h123;
    bus.xpos      = 12'd100;
    bus.ypos      = 12'd200;
    #2;
    check("reset_outputs", 64'(out_vec()), 64'd0);
    check("reset_addr", 64'(bus.pixel_addr), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Remainder of the first frame draws at (0,0).
    line(0, 6, 70);
    line(1, 0, 3);

    // Frame at (100,200): corners, boundaries, transparency, blanking.
    px(0, 0, 12'($urandom));
    line(200, 90, 98);
    px(99, 200, 12'($urandom), 2);
    px(100, 200, 12'($urandom), 1, 12'h000);
    line(200, 101, 163);
    px(164, 200, 12'($urandom), 2);
    line(200, 165, 170);
    line(200, 800, 805);
    px(100, 201, 12'($urandom), 1, 12'h040);
    px(101, 201, 12'($urandom), 2);
    px(102, 201, 12'($urandom), 1, 12'h042);
    line(263, 155, 162);
    px(163, 263, 12'($urandom), 1, 12'hFFF);
    px(164, 263, 12'($urandom), 2);
    line(600, 100, 104);
    px(105, 600, 12'($urandom), 1, 12'h000);

    // Position change mid-frame only takes effect at the next frame start.
    bus.ypos = 12'd20;
    px(0, 0, 12'($urandom));
    line(30, 95, 170);
    bus.xpos = 12'd300;
    px(100, 50, 12'($urandom), 1, 12'h780);
    px(300, 50, 12'($urandom), 2);
    line(50, 295, 370);
    px(0, 0, 12'($urandom));
    px(100, 50, 12'($urandom), 2);
    px(300, 50, 12'($urandom), 1, 12'h780);
    line(50, 95, 170);
    line(50, 295, 370);

    // Right-edge clip: no wrap onto the next line's left edge.
    bus.xpos = 12'd770;
    bus.ypos = 12'd0;
    px(0, 0, 12'($urandom));
    line(5, 760, 798);
    px(799, 5, 12'($urandom), 1, 12'h15D);
    px(800, 5, 12'($urandom), 1, 12'h000);
    line(5, 801, 830);
    line(6, 0, 40);

    // Largest xpos draws nothing.
    bus.xpos = 12'hFFF;
    px(0, 0, 12'($urandom));
    line(0, 1, 70);
    px(64, 1, 12'($urandom), 2);
    line(10, 390, 400);

    // Asynchronous reset mid-line, then redraw at (0,0).
    #2 rst = 1'b1;
    #1;
    check("midreset_outputs", 64'(out_vec()), 64'd0);
    check("midreset_addr", 64'(bus.pixel_addr), 64'd0);
    q.delete();
    aq.delete();
    bus.xpos = 12'd0;
    bus.ypos = 12'd0;
    x_m = 0;
    y_m = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    px(0, 0, 12'($urandom));
    line(0, 1, 70);
    px(0, 1, 12'($urandom), 1, 12'h040);
    line(63, 60, 62);
    px(63, 63, 12'($urandom), 1, 12'hFFF);
    line(64, 0, 5);
    flush();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/draw_image_rom.md
# draw_image_rom

Overlays a 64x64 bitmap, read from an external synchronous image ROM, onto the VGA pixel stream at the position produced by the image position controller (`xpos`/`ypos`). It sits in the video pipeline after the background/rectangle stages and before the VGA output register. It consumes the controller's position and the incoming timing/RGB stream, generates ROM addresses, and emits the same timing stream delayed to match ROM latency with the image pixels merged in.

## Interface
Parameters:
- `IMG_W`, 64: image width in pixels; power of two, addressing uses log2 bits.
- `IMG_H`, 64: image height in pixels; power of two.
- `KEY_COLOR`, 12'hF0F: transparent colour; ROM pixels equal to it show `rgb_in`.

Ports:
- Reset `rst`, asynchronous, active-high; clock `clk`.
- `clk`  in  1  pixel clock, 40 MHz, 800x600 mode.
- `rst`  in  1  async reset, active-high.
- `hcount_in`, `vcount_in`  in  11 each  current pixel coordinates.
- `hsync_in`, `vsync_in`, `hblnk_in`, `vblnk_in`  in  1 each  timing flags.
- `rgb_in`  in  12  upstream pixel colour.
- `xpos`, `ypos`  in  12 each  image top-left corner from the position controller.
- `rgb_pixel`  in  12  ROM data; valid one clock after `pixel_addr` is presented.
- `pixel_addr`  out  12  ROM address, `{row[5:0], col[5:0]}`.
- `hcount_out`, `vcount_out`  out  11 each  delayed coordinates.
- `hsync_out`, `vsync_out`, `hblnk_out`, `vblnk_out`  out  1 each  delayed flags.
- `rgb_out`  out  12  merged colour.

## Operation
- Position latch: `x_l`/`y_l` load `xpos`/`ypos` only in the cycle where `hcount_in==0 && vcount_in==0`. Otherwise they hold, so position changes never tear mid-frame.
- Stage 1, registered on the edge that samples the inputs:
  - `in_rect = (hcount_in >= x_l) && (hcount_in < x_l+IMG_W) && (vcount_in >= y_l) && (vcount_in < y_l+IMG_H)`.
  - All compares are done at 13 bits so `x_l+IMG_W` never wraps. `xpos=12'hFFF` draws nothing.
  - `pixel_addr <= {vcount_in - y_l, hcount_in - x_l}`, each truncated to 6 bits.
  - Outside the rectangle the address is don't-care, but it must still be driven deterministically (0).
- Stage 2: ROM registers the address; `rgb_pixel` is valid.
- Stage 3 (output register):
  - If `hblnk|vblnk` (delayed): `rgb_out = 0`.
  - Else if `in_rect` (delayed) and `rgb_pixel != KEY_COLOR`: `rgb_out = rgb_pixel`.
  - Otherwise: `rgb_out = rgb_in` (delayed).
- Pipeline behaviour:
  - Timing and `rgb_in` pass through a delay line aligned with stage 3.
  - No stalls and no handshake; one pixel per clock continuously.

## Timing
- Latency: an input sampled at edge n appears on all outputs after edge n+3, i.e. 3 clocks. `pixel_addr` appears after edge n+1.
- Reset values: all outputs 0, including `pixel_addr`, `rgb_out`, all delayed counts and flags. Internal latches and delay lines are also 0 (`x_l=y_l=0`).
- First frame after reset: the image draws at (0,0) until the next frame-start latch.
- Reset mid-frame: outputs go to 0 immediately (async). After release, the first valid output follows 3 clocks later; the old position is not retained.
- Frame-start coincides with a `xpos` change: the new value is latched and used for the whole frame.
- Image partially off-screen (`xpos > 800-64`): the off-screen part is masked by blanking; visible columns are correct; there is no address wrap onto the left edge.

## Structure
- Shared package `vga_pkg`: `H_ACTIVE=800`, `V_ACTIVE=600`, count and RGB widths, `IMG_W`/`IMG_H` defaults, `KEY_COLOR`.
- One sub-module, `signal_delay` (parameters WIDTH, DEPTH): a shift-register delay with async reset to 0. It is instantiated once for the packed `{hcount, vcount, hsync, vsync, hblnk, vblnk, rgb_in}` bus with DEPTH=3, and once for `in_rect` with DEPTH=2 after stage 1.
- The image ROM is external, not instantiated here.

## Test plan
- Reset, then a full frame with `xpos=100, ypos=200`, ROM model `data = addr`:
  - Pixel (100,200) gives `rgb_out=12'h000`, address 0.
  - Pixel (163,263) gives `rgb_out=12'hFFF`.
  - (99,200) and (164,200) give `rgb_in`.
- Latency check: a toggling `hsync_in` pattern appears on `hsync_out` exactly 3 clocks later; `hcount_out` equals `hcount_in` 3 clocks earlier.
- Tearing check: change `xpos` from 100 to 300 at `vcount_in=50`. The image stays at x=100 until the next frame, then moves to 300.
- Transparency: ROM returns `12'hF0F` at address 65. Output pixel (101,201) equals `rgb_in`; neighbouring pixels show ROM data.
- Edge clip: with `xpos=770`, columns 770..799 show the image; `hblnk` region outputs 0; no image pixels at hcount 0..33 of the next line.
- Async reset asserted mid-line: all outputs 0 within the same cycle. After release with `xpos=0, ypos=0`, the next frame draws at (0,0).
